// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780-style LCD power-on init plus valid/ready byte writer,
// paced by strobes derived from the slow clk_en_in reference.
module lcd_cmd_sequencer #(
  parameter int PWRUP_STROBES = 16,
  parameter int E_STROBES     = 1,
  parameter int CMD_WAIT      = 2,
  parameter int CLR_WAIT      = 80
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clk_en_in,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);
  localparam int CW = 16;
  typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_EHIGH, S_HOLD, S_WAIT, S_IDLE} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, r_prev, w_strobe;
  logic [CW-1:0] r_cnt, w_limit;
  logic [1:0] r_idx;
  logic r_rs, r_init_done, r_ready, r_e;
  logic [7:0] r_data;
  logic w_long, w_done, w_accept, w_more;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h06 : 8'h01;
  endfunction

  assign w_strobe = r_sync2 & ~r_prev;
  // clear and home need the long busy wait; character data never does
  assign w_long   = !r_rs && (r_data == 8'h01 || r_data == 8'h02);
  assign w_more   = !r_init_done && r_idx != 2'd3;
  assign w_done   = w_strobe && r_cnt == w_limit - CW'(1);
  assign w_accept = r_state == S_IDLE && r_ready && wr_valid;

  always_comb begin
    w_limit = r_state == S_PWRUP ? CW'(PWRUP_STROBES) :
              r_state == S_EHIGH ? CW'(E_STROBES) :
              r_state == S_WAIT  ? (w_long ? CW'(CLR_WAIT) : CW'(CMD_WAIT)) : CW'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PWRUP: if (w_done) w_next = S_SETUP;
      S_SETUP: if (w_done) w_next = S_EHIGH;
      S_EHIGH: if (w_done) w_next = S_HOLD;
      S_HOLD:  if (w_done) w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = w_more ? S_SETUP : S_IDLE;
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      default: w_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_PWRUP;
    else r_state <= w_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {r_sync1, r_sync2, r_prev} <= 3'b000;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
      r_ready     <= 1'b0;
      r_e         <= 1'b0;
    end else begin
      {r_sync1, r_sync2, r_prev} <= {clk_en_in, r_sync1, r_sync2};
      r_cnt   <= (w_done || r_state == S_IDLE) ? '0 : r_cnt + CW'(w_strobe);
      r_e     <= w_next == S_EHIGH;
      r_ready <= r_state == S_IDLE && r_init_done && !w_accept;
      if (r_state == S_PWRUP && w_done) begin
        r_idx  <= 2'd0;
        r_rs   <= 1'b0;
        r_data <= init_byte(2'd0);
      end
      if (r_state == S_WAIT && w_done && !r_init_done) begin
        if (w_more) begin
          r_idx  <= r_idx + 2'd1;
          r_data <= init_byte(r_idx + 2'd1);
        end else r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_rs   <= wr_rs;
        r_data <= wr_data;
      end
    end
  end

  assign lcd_e     = r_e;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = r_data;
  assign wr_ready  = r_ready;
  assign init_done = r_init_done;
endmodule
